// File: rtl/lamp_drv_pkg.sv
// Shared definitions for the lamp driver: lamp code values, the driver
// state encoding and the legal phase-order successor function.
package lamp_drv_pkg;

   typedef logic [1:0] lamp_code_t;

   localparam lamp_code_t CODE_DARK  = 2'b00;
   localparam lamp_code_t CODE_RED   = 2'b01;
   localparam lamp_code_t CODE_AMBER = 2'b11;
   localparam lamp_code_t CODE_GREEN = 2'b10;

   typedef enum logic [1:0] {
      S_DARK  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } lamp_state_t;

   // The only code allowed to follow the given one while running.
   function automatic lamp_code_t legal_successor(input lamp_code_t cur);
      lamp_code_t nxt;
      case (cur)
         CODE_RED:   nxt = CODE_AMBER;
         CODE_AMBER: nxt = CODE_GREEN;
         CODE_GREEN: nxt = CODE_RED;
         default:    nxt = CODE_DARK;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/lamp_code_filter.sv
// Input conditioning for the lamp code: two-flop synchroniser followed by a
// run-length filter. A code is accepted once FILT_CYCLES consecutive
// synchronised samples agree and differ from the code already accepted;
// code_valid pulses for one cycle alongside each newly accepted code.
module lamp_code_filter
   import lamp_drv_pkg::*;
#(
   parameter int unsigned FILT_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] code_in,
   output logic [1:0] code_out,
   output logic       code_valid
);

   lamp_code_t sync1, sync2, cand;
   logic [3:0] run_cnt, run_cnt_d;
   logic       accept;

   // Run length of the current candidate, including this cycle's sample.
   always_comb begin
      run_cnt_d = 4'd1;
      if (sync2 == cand) begin
         run_cnt_d = (run_cnt == 4'hF) ? run_cnt : run_cnt + 4'd1;
      end
      accept = (run_cnt_d >= 4'(FILT_CYCLES)) && (sync2 != code_out);
   end

   // Synchroniser, candidate tracking and accepted-code register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1      <= CODE_DARK;
         sync2      <= CODE_DARK;
         cand       <= CODE_DARK;
         run_cnt    <= '0;
         code_out   <= CODE_DARK;
         code_valid <= 1'b0;
      end else begin
         sync1      <= code_in;
         sync2      <= sync1;
         cand       <= sync2;
         run_cnt    <= run_cnt_d;
         code_valid <= accept;
         if (accept) begin
            code_out <= sync2;
         end
      end
   end

endmodule

// File: rtl/lamp_driver.sv
// Lamp driver: filters the controller's lamp code, enforces the
// RED->AMBER->GREEN->RED order, watches for stalled phases and, on any
// violation, latches a fault and flashes amber until reset.
// Optional feature macro LAMP_DRIVER_PWM_EN: when defined, lit lamps are
// gated by a free-running 8-bit PWM counter (on while counter < DUTY);
// otherwise lit lamps are driven constantly and DUTY is ignored.
module lamp_driver
   import lamp_drv_pkg::*;
#(
   parameter int unsigned FILT_CYCLES = 4,
   parameter int unsigned TIMEOUT     = 1000,
   parameter int unsigned BLINK_HALF  = 50,
   parameter int unsigned DUTY        = 128
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       r_in,
   input  logic       g_in,
   output logic       lamp_red,
   output logic       lamp_amber,
   output logic       lamp_green,
   output logic [1:0] phase,
   output logic       fault
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   localparam int unsigned BL_W = $clog2(BLINK_HALF + 1);

   lamp_state_t state, state_d;
   lamp_code_t  acc_code, phase_d;
   logic        code_valid;
   logic        fault_d;
   logic [WD_W-1:0] wd_cnt, wd_cnt_d;
   logic [BL_W-1:0] bl_cnt, bl_cnt_d;
   logic        bl_on, bl_on_d;
   logic        red_d, amber_d, green_d;
   logic        pwm_on;

   lamp_code_filter #(
      .FILT_CYCLES(FILT_CYCLES)
   ) u_filter (
      .clk        (clk),
      .reset_n    (reset_n),
      .code_in    ({r_in, g_in}),
      .code_out   (acc_code),
      .code_valid (code_valid)
   );

`ifdef LAMP_DRIVER_PWM_EN
   logic [7:0] pwm_cnt, pwm_cnt_d;

   // Gate is evaluated on the counter value the lamps will coincide with.
   always_comb begin
      pwm_cnt_d = pwm_cnt + 8'd1;
      pwm_on    = ({1'b0, pwm_cnt_d} < 9'(DUTY));
   end

   // Free-running PWM counter, wraps 255 -> 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt_d;
      end
   end
`else
   localparam int unsigned UNUSED_DUTY = DUTY;
   assign pwm_on = 1'b1;
`endif

   // Next-state, phase, watchdog, blink and lamp decode.
   always_comb begin
      state_d  = state;
      phase_d  = phase;
      fault_d  = fault;
      wd_cnt_d = wd_cnt;
      bl_cnt_d = bl_cnt;
      bl_on_d  = bl_on;
      case (state)
         S_DARK: begin
            if (code_valid && (acc_code != CODE_DARK)) begin
               state_d  = S_RUN;
               phase_d  = acc_code;
               wd_cnt_d = '0;
            end
         end
         S_RUN: begin
            // An accepted change takes priority over a simultaneous timeout.
            if (code_valid) begin
               wd_cnt_d = '0;
               if (acc_code == legal_successor(phase)) begin
                  phase_d = acc_code;
               end else begin
                  state_d  = S_FAULT;
                  fault_d  = 1'b1;
                  bl_cnt_d = '0;
                  bl_on_d  = 1'b1;
               end
            end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
               state_d  = S_FAULT;
               fault_d  = 1'b1;
               bl_cnt_d = '0;
               bl_on_d  = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt + 1'b1;
            end
         end
         S_FAULT: begin
            if (bl_cnt == BL_W'(BLINK_HALF - 1)) begin
               bl_cnt_d = '0;
               bl_on_d  = ~bl_on;
            end else begin
               bl_cnt_d = bl_cnt + 1'b1;
            end
         end
         default: begin
            state_d = S_DARK;
         end
      endcase

      red_d   = 1'b0;
      amber_d = 1'b0;
      green_d = 1'b0;
      if (state_d == S_RUN) begin
         red_d   = (phase_d == CODE_RED)   && pwm_on;
         amber_d = (phase_d == CODE_AMBER) && pwm_on;
         green_d = (phase_d == CODE_GREEN) && pwm_on;
      end else if (state_d == S_FAULT) begin
         amber_d = bl_on_d && pwm_on;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_DARK;
         phase      <= CODE_DARK;
         fault      <= 1'b0;
         wd_cnt     <= '0;
         bl_cnt     <= '0;
         bl_on      <= 1'b0;
         lamp_red   <= 1'b0;
         lamp_amber <= 1'b0;
         lamp_green <= 1'b0;
      end else begin
         state      <= state_d;
         phase      <= phase_d;
         fault      <= fault_d;
         wd_cnt     <= wd_cnt_d;
         bl_cnt     <= bl_cnt_d;
         bl_on      <= bl_on_d;
         lamp_red   <= red_d;
         lamp_amber <= amber_d;
         lamp_green <= green_d;
      end
   end

endmodule

// File: tb/tb_lamp_driver.sv
// Directed testbench for lamp_driver: table of held codes with expected
// phase/fault/lamps, plus hand-written sequences for latency, glitch,
// illegal order, fault flash, watchdog and change-versus-timeout.
`timescale 1ns/1ps
module tb_lamp_driver;

   localparam int unsigned DUTY_TB = 64;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       r_in = 1'b0;
   logic       g_in = 1'b0;
   logic       lamp_red, lamp_amber, lamp_green, fault;
   logic [1:0] phase;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc;

   typedef struct {
      logic [1:0]  code;
      int unsigned hold;
      logic [1:0]  exp_phase;
      logic        exp_fault;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   lamp_driver #(
      .FILT_CYCLES (4),
      .TIMEOUT     (1000),
      .BLINK_HALF  (50),
      .DUTY        (DUTY_TB)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .r_in       (r_in),
      .g_in       (g_in),
      .lamp_red   (lamp_red),
      .lamp_amber (lamp_amber),
      .lamp_green (lamp_green),
      .phase      (phase),
      .fault      (fault)
   );

   // Edges since reset release; equals the PWM counter value modulo 256.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   function automatic logic gate_now();
`ifdef LAMP_DRIVER_PWM_EN
      return ((cyc % 256) < DUTY_TB);
`else
      return 1'b1;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [1:0] code);
      {r_in, g_in} = code;
   endtask

   task automatic check_run(input string name, input logic [1:0] exp_phase, input logic exp_fault);
      logic g;
      g = gate_now();
      check($sformatf("%s.phase", name), 32'(phase), 32'(exp_phase));
      check($sformatf("%s.fault", name), 32'(fault), 32'(exp_fault));
      check($sformatf("%s.red", name),   32'(lamp_red),   32'((exp_phase == 2'b01) && g));
      check($sformatf("%s.amber", name), 32'(lamp_amber), 32'((exp_phase == 2'b11) && g));
      check($sformatf("%s.green", name), 32'(lamp_green), 32'((exp_phase == 2'b10) && g));
   endtask

   task automatic check_faulted(input string name, input logic [1:0] exp_phase);
      check($sformatf("%s.fault", name), 32'(fault), 32'd1);
      check($sformatf("%s.phase", name), 32'(phase), 32'(exp_phase));
      check($sformatf("%s.red", name),   32'(lamp_red), 32'd0);
      check($sformatf("%s.green", name), 32'(lamp_green), 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(2'b00);
      tick(2);
      reset_n = 1'b1;
   endtask

   initial begin
      int unsigned cnt_red, cnt_other, cnt_multi, errs;
      logic exp_amb;

      tbl[0] = '{2'b01, 13,  2'b01, 1'b0};
      tbl[1] = '{2'b11, 100, 2'b11, 1'b0};
      tbl[2] = '{2'b10, 100, 2'b10, 1'b0};
      tbl[3] = '{2'b01, 100, 2'b01, 1'b0};
      tbl[4] = '{2'b10, 3,   2'b01, 1'b0};
      tbl[5] = '{2'b01, 20,  2'b01, 1'b0};

      // Reset values while reset is held.
      #1 reset_n = 1'b0;
      drive(2'b00);
      #11;
      check("rst.phase", 32'(phase), 32'd0);
      check("rst.fault", 32'(fault), 32'd0);
      check("rst.lamps", 32'({lamp_red, lamp_amber, lamp_green}), 32'd0);

      // Release, then RED: first sample edge is the first post-release edge.
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      drive(2'b01);
      tick(1);
      check("rel.phase", 32'(phase), 32'd0);
      check("rel.lamps", 32'({lamp_red, lamp_amber, lamp_green}), 32'd0);
      tick(5);
      check("lat6.phase", 32'(phase), 32'd0);
      check("lat6.red", 32'(lamp_red), 32'd0);
      tick(1);
      check_run("lat7", 2'b01, 1'b0);

      // Legal sequence and glitch rejection.
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].code);
         tick(tbl[i].hold);
         check_run($sformatf("vec%0d", i), tbl[i].exp_phase, tbl[i].exp_fault);
      end

      // Duty and one-hot over a full PWM period in steady RED.
      cnt_red = 0;
      cnt_other = 0;
      cnt_multi = 0;
      for (int i = 0; i < 256; i++) begin
         if (lamp_red) cnt_red++;
         if (lamp_amber || lamp_green) cnt_other++;
         if ((32'(lamp_red) + 32'(lamp_amber) + 32'(lamp_green)) > 1) cnt_multi++;
         tick(1);
      end
`ifdef LAMP_DRIVER_PWM_EN
      check("duty.red", cnt_red, DUTY_TB);
`else
      check("duty.red", cnt_red, 256);
`endif
      check("duty.other", cnt_other, 0);
      check("duty.multi", cnt_multi, 0);

      // Illegal RED -> GREEN.
      drive(2'b10);
      tick(6);
      check("ill6.fault", 32'(fault), 32'd0);
      check("ill6.phase", 32'(phase), 32'd1);
      tick(1);
      check_faulted("ill7", 2'b01);
      errs = 0;
      for (int i = 0; i < 200; i++) begin
         exp_amb = (((i / 50) % 2) == 0) && gate_now();
         if (lamp_amber !== exp_amb) errs++;
         if (lamp_red || lamp_green) errs++;
         tick(1);
      end
      check("blink.errs", errs, 0);
      drive(2'b11);
      tick(30);
      check_faulted("ign11", 2'b01);
      drive(2'b01);
      tick(30);
      check_faulted("ign01", 2'b01);
      drive(2'b00);
      tick(30);
      check_faulted("ign00", 2'b01);

      // Asynchronous reset mid-cycle.
      #3 reset_n = 1'b0;
      #1;
      check("arst.fault", 32'(fault), 32'd0);
      check("arst.phase", 32'(phase), 32'd0);
      check("arst.lamps", 32'({lamp_red, lamp_amber, lamp_green}), 32'd0);
      @(posedge clk);
      #1;

      // Watchdog: AMBER held past TIMEOUT.
      do_reset();
      drive(2'b11);
      tick(7);
      check_run("wd.enter", 2'b11, 1'b0);
      tick(999);
      check_run("wd.999", 2'b11, 1'b0);
      tick(1);
      check_faulted("wd.1000", 2'b11);
      check("wd.amber", 32'(lamp_amber), 32'(gate_now()));

      // Accepted legal change on the timeout cycle wins.
      do_reset();
      drive(2'b11);
      tick(7);
      check_run("race.enter", 2'b11, 1'b0);
      tick(993);
      drive(2'b10);
      tick(6);
      check_run("race.pre", 2'b11, 1'b0);
      tick(1);
      check_run("race.edge", 2'b10, 1'b0);
      tick(20);
      check_run("race.post", 2'b10, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
